pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 69 ++++++
 tb/tb_pipe_stage_buf.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic buffer between two pipeline stages: a circular buffer with hold/flush control.
// The head entry is read straight from storage, so a push shows up on the output one cycle later.
module pipe_stage_buf #(
  parameter int                WIDTH  = 32,
  parameter int                DEPTH  = 2,
  parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
  input  logic                         clock,
  input  logic                         nReset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         hold,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A full buffer still accepts when the head is leaving this cycle.
  assign in_ready  = (count != CNT_FULL) | (out_ready & ~hold);
  assign out_valid = (count != '0) & ~hold;
  assign out_data  = out_valid ? mem[rd_ptr] : BUBBLE;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is left unreset; pointers and count alone define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a DEPTH=2 instance (zero bubble) and a DEPTH=3 instance (bubble 8'hEE),
// each checked cycle by cycle against a queue model of the buffer contents.
module tb_pipe_stage_buf;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       h;
    logic       f;
  } stim_t;

  logic clock = 1'b0;
  logic nReset;
  always #5 clock = ~clock;

  logic       a_iv, a_ir, a_ov, a_or, a_hold, a_flush;
  logic [7:0] a_id, a_od;
  logic [1:0] a_cnt;
  logic       b_iv, b_ir, b_ov, b_or, b_hold, b_flush;
  logic [7:0] b_id, b_od;
  logic [1:0] b_cnt;

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2)) u_a (
    .clock(clock), .nReset(nReset),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .hold(a_hold), .flush(a_flush), .count(a_cnt)
  );

  pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'hEE)) u_b (
    .clock(clock), .nReset(nReset),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .hold(b_hold), .flush(b_flush), .count(b_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  logic       e_ready, e_valid, o_ready, o_valid;
  logic [7:0] e_data, o_data;
  logic [3:0] e_count, o_count;

  // Drive one cycle on the DEPTH=2 instance, capture outputs mid-cycle, advance the model at the edge.
  task automatic step_a(input stim_t s);
    a_iv = s.v; a_id = s.d; a_or = s.rdy; a_hold = s.h; a_flush = s.f;
    @(negedge clock);
    o_ready = a_ir; o_valid = a_ov; o_data = a_od; o_count = {2'b00, a_cnt};
    e_count = 4'(qa.size());
    e_ready = (qa.size() < 2) || (s.rdy && !s.h);
    e_valid = (qa.size() != 0) && !s.h;
    e_data  = e_valid ? qa[0] : 8'h00;
    @(posedge clock);
    if (s.f) qa.delete();
    else begin
      if (e_valid && s.rdy) void'(qa.pop_front());
      if (s.v && e_ready) qa.push_back(s.d);
    end
    #1;
  endtask

  task automatic step_b(input stim_t s);
    b_iv = s.v; b_id = s.d; b_or = s.rdy; b_hold = s.h; b_flush = s.f;
    @(negedge clock);
    o_ready = b_ir; o_valid = b_ov; o_data = b_od; o_count = {2'b00, b_cnt};
    e_count = 4'(qb.size());
    e_ready = (qb.size() < 3) || (s.rdy && !s.h);
    e_valid = (qb.size() != 0) && !s.h;
    e_data  = e_valid ? qb[0] : 8'hEE;
    @(posedge clock);
    if (s.f) qb.delete();
    else begin
      if (e_valid && s.rdy) void'(qb.pop_front());
      if (s.v && e_ready) qb.push_back(s.d);
    end
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({a_cnt, a_ov, a_od, a_ir} !== {2'd0, 1'b0, 8'h00, 1'b1})
      $display("FAIL reset_a: got cnt=%0d vld=%b data=%h rdy=%b, want cnt=0 vld=0 data=00 rdy=1",
               a_cnt, a_ov, a_od, a_ir);
    else n_pass++;
    n_checks++;
    if ({b_cnt, b_ov, b_od, b_ir} !== {2'd0, 1'b0, 8'hEE, 1'b1})
      $display("FAIL reset_b: got cnt=%0d vld=%b data=%h rdy=%b, want cnt=0 vld=0 data=ee rdy=1",
               b_cnt, b_ov, b_od, b_ir);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    stim_t seq [6];
    seq = '{'{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0}, '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0}};
    foreach (seq[i]) begin
      step_a(seq[i]);
      n_checks++;
      if ({o_ready, o_valid, o_data, o_count} !== {e_ready, e_valid, e_data, e_count})
        $display("FAIL fill_drain step %0d: got rdy=%b vld=%b data=%h cnt=%0d, want rdy=%b vld=%b data=%h cnt=%0d",
                 i, o_ready, o_valid, o_data, o_count, e_ready, e_valid, e_data, e_count);
      else n_pass++;
    end
  endtask

  task automatic test_full_passthru();
    stim_t seq [6];
    seq = '{'{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0}, '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0},
            '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0}, '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0}};
    foreach (seq[i]) begin
      step_a(seq[i]);
      n_checks++;
      if ({o_ready, o_valid, o_data, o_count} !== {e_ready, e_valid, e_data, e_count})
        $display("FAIL full_passthru step %0d: got rdy=%b vld=%b data=%h cnt=%0d, want rdy=%b vld=%b data=%h cnt=%0d",
                 i, o_ready, o_valid, o_data, o_count, e_ready, e_valid, e_data, e_count);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    stim_t seq [11];
    seq = '{'{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0}, '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0}, '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0}};
    foreach (seq[i]) begin
      step_a(seq[i]);
      n_checks++;
      if ({o_ready, o_valid, o_data, o_count} !== {e_ready, e_valid, e_data, e_count})
        $display("FAIL hold step %0d: got rdy=%b vld=%b data=%h cnt=%0d, want rdy=%b vld=%b data=%h cnt=%0d",
                 i, o_ready, o_valid, o_data, o_count, e_ready, e_valid, e_data, e_count);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    stim_t seq [10];
    seq = '{'{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0}, '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0},
            '{1'b1, 8'hD4, 1'b0, 1'b0, 1'b1}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0}, '{1'b1, 8'h71, 1'b0, 1'b0, 1'b0},
            '{1'b1, 8'h72, 1'b1, 1'b1, 1'b1}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0},
            '{1'b1, 8'h73, 1'b1, 1'b0, 1'b0}, '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0}};
    foreach (seq[i]) begin
      step_a(seq[i]);
      n_checks++;
      if ({o_ready, o_valid, o_data, o_count} !== {e_ready, e_valid, e_data, e_count})
        $display("FAIL flush step %0d: got rdy=%b vld=%b data=%h cnt=%0d, want rdy=%b vld=%b data=%h cnt=%0d",
                 i, o_ready, o_valid, o_data, o_count, e_ready, e_valid, e_data, e_count);
      else n_pass++;
      n_checks++;
      if (o_valid && (o_data === 8'hD4 || o_data === 8'h72))
        $display("FAIL flush_dropped step %0d: got data=%h, want a squashed payload never to appear", i, o_data);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seen[$];
    stim_t s;
    for (int i = 0; i < 12; i++) begin
      s = '{(i < 10), 8'(i), 1'b1, 1'b0, 1'b0};
      step_b(s);
      n_checks++;
      if ({o_ready, o_valid, o_data, o_count} !== {e_ready, e_valid, e_data, e_count})
        $display("FAIL wrap step %0d: got rdy=%b vld=%b data=%h cnt=%0d, want rdy=%b vld=%b data=%h cnt=%0d",
                 i, o_ready, o_valid, o_data, o_count, e_ready, e_valid, e_data, e_count);
      else n_pass++;
      n_checks++;
      if (o_count > 4'd1) $display("FAIL wrap_count step %0d: got cnt=%0d, want at most 1", i, o_count);
      else n_pass++;
      if (o_valid) seen.push_back(o_data);
    end
    n_checks++;
    if (seen.size() != 10) $display("FAIL wrap_len: got %0d outputs, want 10", seen.size());
    else n_pass++;
    foreach (seen[i]) begin
      n_checks++;
      if (seen[i] !== 8'(i)) $display("FAIL wrap_order idx %0d: got %h, want %h", i, seen[i], 8'(i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    s = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0}; step_a(s);
    s = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0}; step_a(s);
    a_iv = 1'b1; a_id = 8'h5A; a_or = 1'b0;
    @(negedge clock);
    nReset = 1'b0;
    #1;
    n_checks++;
    if ({a_cnt, a_ov, a_od, a_ir} !== {2'd0, 1'b0, 8'h00, 1'b1})
      $display("FAIL reset_mid_async: got cnt=%0d vld=%b data=%h rdy=%b, want cnt=0 vld=0 data=00 rdy=1",
               a_cnt, a_ov, a_od, a_ir);
    else n_pass++;
    qa.delete();
    qb.delete();
    #3 nReset = 1'b1;
    @(posedge clock);
    #1;
    qa.push_back(8'h5A);
    n_checks++;
    if ({a_cnt, a_ov, a_od} !== {2'd1, 1'b1, 8'h5A})
      $display("FAIL reset_mid_first_push: got cnt=%0d vld=%b data=%h, want cnt=1 vld=1 data=5a",
               a_cnt, a_ov, a_od);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      s = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      step_a(s);
      n_checks++;
      if ({o_ready, o_valid, o_data, o_count} !== {e_ready, e_valid, e_data, e_count})
        $display("FAIL reset_mid_drain step %0d: got rdy=%b vld=%b data=%h cnt=%0d, want rdy=%b vld=%b data=%h cnt=%0d",
                 i, o_ready, o_valid, o_data, o_count, e_ready, e_valid, e_data, e_count);
      else n_pass++;
    end
  endtask

  initial begin
    nReset = 1'b0;
    a_iv = 1'b0; a_id = 8'h00; a_or = 1'b0; a_hold = 1'b0; a_flush = 1'b0;
    b_iv = 1'b0; b_id = 8'h00; b_or = 1'b0; b_hold = 1'b0; b_flush = 1'b0;
    #12;
    test_reset();
    @(negedge clock);
    nReset = 1'b1;
    @(posedge clock);
    #1;
    test_fill_drain();
    test_full_passthru();
    test_hold();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion by 50000 ns, want the sequence to finish");
    $fatal(1, "timeout");
  end

endmodule
